piso_serializer: RTL
====================

Name: piso_serializer

Overview:
Parallel-in serial-out serializer that feeds the siso delay line. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first on a registered serial output. An optional pacing enable holds each bit for more than one cycle. Back-to-back words stream with no idle gap.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32.
IDLE_LEVEL, 1'b0, value driven on so while no word is being shifted.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  synchronous, active-high reset.
din  input  WIDTH  parallel word; sampled only on an accepting edge.
load_valid  input  1  upstream has a word on din.
load_ready  output  1  combinational; serializer can accept din this cycle.
shift_en  input  1  advance-bit enable; when low the current bit is held.
so  output  1  registered serial data; feeds siso si.
busy  output  1  registered; high while a word is being shifted.
done  output  1  registered; one-cycle pulse when the final bit of a word retires.

Behaviour:
- Reset: rst sampled high at a rising edge wins over all other inputs. State returns to IDLE, so=IDLE_LEVEL, busy=0, done=0, shift register=0 and bit counter=0. load_ready=0 while rst=1.
- A reset mid-word abandons the word. No done pulse is generated.
- State IDLE:
  - load_ready=1.
  - An accept occurs when load_valid=1 at a rising edge. shift_en is ignored for acceptance.
  - After the accepting edge: shift register=din, so=din[WIDTH-1], bit counter=WIDTH-1, busy=1, state=SHIFT.
  - Latency from the accepting edge to the MSB on so is 0 cycles, because so updates on that same edge.
- State SHIFT:
  - A rising edge with shift_en=0 changes nothing. The bit is held indefinitely.
  - A rising edge with shift_en=1 and counter>0 drives the next lower bit onto so and decrements the counter.
  - A rising edge with shift_en=1 and counter=0 retires the final (LSB) bit, and done=1 for the next cycle. What follows depends on load_valid:
    - load_valid=1: gapless accept. The new word loads, so=new din[WIDTH-1], counter=WIDTH-1, busy stays 1.
    - load_valid=0: state goes to IDLE, so=IDLE_LEVEL, busy=0.
- load_ready = !rst && (state==IDLE || (state==SHIFT && counter==0 && shift_en)).
- Upstream must hold din/load_valid stable until accepted. A valid that is not accepted has no effect.
- With shift_en tied high, a word occupies exactly WIDTH cycles on so. Continuous valid input gives 100% line utilisation.
- done is asserted for exactly one cycle per completed word, including on gapless transitions.
- din is not sampled outside accepting edges. Changes on din during SHIFT do not affect so.
- Counter width is clog2(WIDTH). The counter never wraps below 0.

Test Plan:
1. WIDTH=8, shift_en=1, rst 2 cycles, then din=8'hA5 with load_valid for 1 cycle.
   -> so=1,0,1,0,0,1,0,1 on 8 consecutive cycles, then 0.
   -> busy high for exactly 8 cycles; done pulses once in the following cycle.
   -> The siso output reproduces the same sequence 4 cycles later.
2. Gapless streaming: load_valid held high with din=8'hFF, then 8'h00.
   -> load_ready is high only in the last-bit cycle of each word.
   -> so shows 8 ones then 8 zeros with no IDLE_LEVEL cycle between.
   -> done pulses twice; busy never drops.
3. Pacing: din=8'hC3, shift_en high every 3rd cycle.
   -> Each bit is held 3 cycles; sequence is 1,1,0,0,0,0,1,1.
   -> din is changed to 8'h00 mid-word and must not alter so.
4. Reset mid-operation: rst asserted after 3 bits of 8'hA5.
   -> Next cycle so=IDLE_LEVEL, busy=0; no done pulse; load_ready=0 during rst and 1 after.
   -> A new word 8'h81 then shifts correctly as 1,0,0,0,0,0,0,1.
5. IDLE_LEVEL=1, WIDTH=4: idle so=1; din=4'h6 -> so=0,1,1,0, then back to 1.
6. Simultaneous events: rst=1 and load_valid=1 on the same edge.
   -> Reset wins; no word is accepted; so=IDLE_LEVEL.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Load handshake, pacing enable and serial-side status of the PISO serializer.
// The master side is the upstream word source; the slave side is the serializer.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             so;
    logic             busy;
    logic             done;

    modport master (
        output din, load_valid, shift_en,
        input  load_ready, so, busy, done
    );

    modport slave (
        input  din, load_valid, shift_en,
        output load_ready, so, busy, done
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: accepts a WIDTH-bit word over valid/ready
// and shifts it out MSB-first on a registered output, gapless between words.
module piso_serializer #(
    parameter int       WIDTH      = 8,
    parameter logic     IDLE_LEVEL = 1'b0
) (
    input logic               clk,
    input logic               rst,
    piso_serializer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-2:0] sreg;
    logic [CW-1:0]    cnt;
    logic             so_r;
    logic             busy_r;
    logic             done_r;
    logic             last;
    logic             ready;
    logic             accept;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last)   state_nxt = bus.load_valid ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The final-bit edge doubles as an accept slot so words stream without a gap.
    always_comb begin
        last   = (state == SHIFT) && (cnt == '0) && bus.shift_en;
        ready  = !rst && ((state == IDLE) || last);
        accept = ready && bus.load_valid;
    end

    // sreg only holds the bits still waiting behind the one currently on so.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg   <= '0;
            cnt    <= '0;
            so_r   <= IDLE_LEVEL;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= last;
            if (accept) begin
                sreg   <= bus.din[WIDTH-2:0];
                cnt    <= CW'(WIDTH - 1);
                so_r   <= bus.din[WIDTH-1];
                busy_r <= 1'b1;
            end else if (last) begin
                so_r   <= IDLE_LEVEL;
                busy_r <= 1'b0;
            end else if ((state == SHIFT) && bus.shift_en) begin
                so_r <= sreg[WIDTH-2];
                sreg <= sreg << 1;
                cnt  <= cnt - 1'b1;
            end
        end
    end

    assign bus.load_ready = ready;
    assign bus.so         = so_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
endmodule
